// File: rtl/rf_pkg.sv
// rf_pkg: sizing constants and shared types for the register file and its
// write-port arbiter.
//   DATA_WIDTH : register data width
//   ADDR_WIDTH : register select width
//   NUM_REGS   : number of registers (2**ADDR_WIDTH)
package rf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // Identifies which writeback requester won the port.
  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/register_file_write_arbiter_if.sv
// register_file_write_arbiter_if: the two writeback valid/ready channels
// (requester 0 = ALU writeback, requester 1 = memory-load writeback).
//   reqN_valid : requester has a write to issue
//   reqN_addr  : destination register
//   reqN_data  : value to write
//   reqN_ready : grant; a transfer happens on an edge with valid && ready
// Modports: master = requester side, slave = arbiter side.
interface register_file_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
);

  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/register_file_write_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-request round-robin arbiter with a single last_grant bit.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector (valids), bit 0 = requester 0
//   grant      : one-hot (or zero) grant vector, combinational
//   handshake  : a grant is being taken this cycle (grant implies valid)
// A lone requester always wins; on a conflict the requester not named by
// last_grant wins. Grants are forced low while reset is high.
module rr_arbiter_2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       handshake
);

  logic last_grant;

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (req[0] && (!req[1] || (last_grant == GRANT_REQ1))) begin
        grant[0] = 1'b1;
      end else if (req[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  // A grant is only ever issued to a valid requester, so any grant is a transfer.
  assign handshake = |grant;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_REQ1;  // requester 0 wins the first conflict
    end else if (handshake) begin
      last_grant <= grant[1] ? GRANT_REQ1 : GRANT_REQ0;
    end
  end

endmodule

// File: rtl/register_file_write_arbiter.sv
// register_file_write_arbiter: shares the register file's single write port
// between ALU writeback (requester 0) and memory-load writeback (requester 1).
// Optional feature macro: RF_SCOREBOARD_EN (pending-write busy scoreboard).
//   clk, reset          : clock, synchronous active-high reset
//   bus                 : both writeback valid/ready channels (slave side)
//   rf_port_c           : register file write data
//   rf_decoder_control  : register file write select
//   rf_load_enable      : register file write enable (one cycle per write)
//   reserve_valid/addr  : issue stage marks a destination as pending
//   a_select, b_select  : register file read selects
//   a_busy, b_busy      : selected register has a write outstanding
module register_file_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = rf_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  register_file_write_arbiter_if.slave bus,
  output logic [DATA_WIDTH-1:0] rf_port_c,
  output logic [ADDR_WIDTH-1:0] rf_decoder_control,
  output logic                  rf_load_enable,
  input  logic                  reserve_valid,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  input  logic [ADDR_WIDTH-1:0] a_select,
  input  logic [ADDR_WIDTH-1:0] b_select,
  output logic                  a_busy,
  output logic                  b_busy
);

  logic [1:0] grant;
  logic       handshake;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({bus.req1_valid, bus.req0_valid}),
    .grant     (grant),
    .handshake (handshake)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // Output stage: one registered write per handshake; with no handshake the
  // enable drops and address/data hold their last values. Reset on the same
  // edge as a handshake drops that write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_load_enable     <= 1'b0;
      rf_decoder_control <= '0;
      rf_port_c          <= '0;
    end else begin
      rf_load_enable <= handshake;
      if (handshake) begin
        rf_decoder_control <= grant[1] ? bus.req1_addr : bus.req0_addr;
        rf_port_c          <= grant[1] ? bus.req1_data : bus.req0_data;
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;

  // The clear comes from the write landing this edge; the set is written
  // afterwards so a same-edge reservation of that register wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (rf_load_enable) begin
        busy[rf_decoder_control] <= 1'b0;
      end
      if (reserve_valid) begin
        busy[reserve_addr] <= 1'b1;
      end
    end
  end

  assign a_busy = busy[a_select];
  assign b_busy = busy[b_select];
`else
  // No scoreboard: reservation and read-select inputs have no effect.
  logic unused_scoreboard_inputs;
  assign unused_scoreboard_inputs = ^{reserve_valid, reserve_addr, a_select, b_select};

  assign a_busy = 1'b0;
  assign b_busy = 1'b0;
`endif

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// tb_register_file_write_arbiter: scoreboard-based bench. Expected writes are
// pushed to a queue when the bench's own arbitration model predicts a
// handshake and popped/compared when the write port presents them.
module tb_register_file_write_arbiter;
  import rf_pkg::*;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

`ifdef RF_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [DATA_WIDTH-1:0] rf_port_c;
  logic [ADDR_WIDTH-1:0] rf_decoder_control;
  logic                  rf_load_enable;
  logic                  reserve_valid;
  logic [ADDR_WIDTH-1:0] reserve_addr;
  logic [ADDR_WIDTH-1:0] a_select;
  logic [ADDR_WIDTH-1:0] b_select;
  logic                  a_busy;
  logic                  b_busy;

  register_file_write_arbiter_if bus ();

  register_file_write_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus.slave),
    .rf_port_c          (rf_port_c),
    .rf_decoder_control (rf_decoder_control),
    .rf_load_enable     (rf_load_enable),
    .reserve_valid      (reserve_valid),
    .reserve_addr       (reserve_addr),
    .a_select           (a_select),
    .b_select           (b_select),
    .a_busy             (a_busy),
    .b_busy             (b_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  wr_t                   q[$];
  logic                  m_last;
  logic [NUM_REGS-1:0]   m_busy;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;

  // Register file stand-in, loaded by the DUT's write port.
  bit [DATA_WIDTH-1:0] tb_rf[NUM_REGS];
  int                  wr_count[NUM_REGS];

  always @(posedge clk) begin
    if (rf_load_enable === 1'b1) begin
      tb_rf[rf_decoder_control]    <= rf_port_c;
      wr_count[rf_decoder_control] <= wr_count[rf_decoder_control] + 1;
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reserve_valid  = 1'b0;
  endtask

  // One clock cycle: check readies/busy against the model, predict, advance
  // the clock, then pop/compare what the write port presents.
  task automatic step();
    logic e0, e1, ea, eb;
    logic landing_valid;
    wr_t  landing;
    wr_t  w;
    #1;
    landing_valid = (q.size() > 0);
    landing = '0;
    if (landing_valid) landing = q.pop_front();
    if (reset) begin
      e0 = 1'b0;
      e1 = 1'b0;
    end else begin
      e0 = bus.req0_valid && (!bus.req1_valid || m_last);
      e1 = bus.req1_valid && (!bus.req0_valid || !m_last);
    end
    ea = SB_EN ? m_busy[a_select] : 1'b0;
    eb = SB_EN ? m_busy[b_select] : 1'b0;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== {e1, e0}) begin
      errors++;
      $display("FAIL ready: got %b expected %b at %0t", {bus.req1_ready, bus.req0_ready}, {e1, e0}, $time);
    end
    checks++;
    if ({a_busy, b_busy} !== {ea, eb}) begin
      errors++;
      $display("FAIL busy: got a=%b b=%b expected a=%b b=%b at %0t", a_busy, b_busy, ea, eb, $time);
    end
    if (e0 || e1) begin
      w.addr = e1 ? bus.req1_addr : bus.req0_addr;
      w.data = e1 ? bus.req1_data : bus.req0_data;
      q.push_back(w);
      m_last = e1;
    end
    if (reset) begin
      m_busy = '0;
      m_last = 1'b1;
      m_addr = '0;
      m_data = '0;
      q.delete();
    end else begin
      if (landing_valid) m_busy[landing.addr] = 1'b0;
      if (reserve_valid) m_busy[reserve_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      if (rf_load_enable !== 1'b1 || rf_decoder_control !== q[0].addr || rf_port_c !== q[0].data) begin
        errors++;
        $display("FAIL write: got le=%b addr=%0d data=%h expected le=1 addr=%0d data=%h",
                 rf_load_enable, rf_decoder_control, rf_port_c, q[0].addr, q[0].data);
      end
      m_addr = q[0].addr;
      m_data = q[0].data;
    end else begin
      checks++;
      if (rf_load_enable !== 1'b0 || rf_decoder_control !== m_addr || rf_port_c !== m_data) begin
        errors++;
        $display("FAIL idle_hold: got le=%b addr=%0d data=%h expected le=0 addr=%0d data=%h",
                 rf_load_enable, rf_decoder_control, rf_port_c, m_addr, m_data);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_addr  = 4'd1;
    bus.req1_addr  = 4'd2;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    reserve_addr   = '0;
    a_select       = 4'd0;
    b_select       = 4'd15;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready});
    end
    checks++;
    if (rf_load_enable !== 1'b0 || rf_decoder_control !== '0 || rf_port_c !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got le=%b addr=%0d data=%h expected 0/0/0",
               rf_load_enable, rf_decoder_control, rf_port_c);
    end
    checks++;
    if ({a_busy, b_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 00", {a_busy, b_busy});
    end
    m_last = 1'b1;
    m_busy = '0;
    m_addr = '0;
    m_data = '0;
    q.delete();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_WIDTH-1:0] obs[4];
    logic [ADDR_WIDTH-1:0] exp_seq[4];
    exp_seq = '{4'd1, 4'd2, 4'd1, 4'd2};
    reset          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd1;
    bus.req0_data  = 32'h1000_0001;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd2;
    bus.req1_data  = 32'h2000_0002;
    for (int i = 0; i < 4; i++) begin
      step();
      obs[i] = rf_decoder_control;
    end
    idle_inputs();
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got addr %0d expected %0d", i, obs[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd3;
    bus.req0_data  = 32'hDEADBEEF;
    step();
    checks++;
    if (rf_load_enable !== 1'b1 || rf_decoder_control !== 4'd3 || rf_port_c !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: got le=%b addr=%0d data=%h expected 1/3/deadbeef",
               rf_load_enable, rf_decoder_control, rf_port_c);
    end
    idle_inputs();
    step();
    checks++;
    if (rf_load_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: got le=%b expected 0", rf_load_enable);
    end
    checks++;
    if (tb_rf[3] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rf: got %h expected deadbeef", tb_rf[3]);
    end
  endtask

  task automatic test_scoreboard();
    a_select      = 4'd5;
    b_select      = 4'd6;
    reserve_valid = 1'b1;
    reserve_addr  = 4'd5;
    step();
    reserve_valid = 1'b0;
    checks++;
    if (a_busy !== SB_EN) begin
      errors++;
      $display("FAIL sb_reserved: got a_busy=%b expected %b", a_busy, SB_EN);
    end
    step();
    step();
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd5;
    bus.req1_data  = 32'h0000_0055;
    step();
    idle_inputs();
    checks++;
    if (a_busy !== SB_EN) begin
      errors++;
      $display("FAIL sb_during_write: got a_busy=%b expected %b", a_busy, SB_EN);
    end
    step();
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: got a_busy=%b expected 0", a_busy);
    end
    step();
  endtask

  task automatic test_same_edge();
    a_select       = 4'd7;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd7;
    bus.req0_data  = 32'h0000_0077;
    step();
    idle_inputs();
    reserve_valid = 1'b1;
    reserve_addr  = 4'd7;
    step();
    reserve_valid = 1'b0;
    checks++;
    if (a_busy !== SB_EN) begin
      errors++;
      $display("FAIL same_edge_set_wins: got a_busy=%b expected %b", a_busy, SB_EN);
    end
    step();
    step();
  endtask

  task automatic test_withdraw();
    int count10;
    count10 = wr_count[10];
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd11;
    bus.req1_data  = 32'h0000_0B0B;
    step();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd9;
    bus.req0_data  = 32'h0000_0909;
    bus.req1_addr  = 4'd10;
    bus.req1_data  = 32'h0000_0A0A;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_ready1: got %b expected 0", bus.req1_ready);
    end
    step();
    idle_inputs();
    step();
    step();
    checks++;
    if (wr_count[10] !== count10) begin
      errors++;
      $display("FAIL withdraw_no_write: got %0d writes to r10 expected %0d", wr_count[10], count10);
    end
  endtask

  task automatic test_reset_mid();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd3;
    bus.req0_data  = 32'h1234_5678;
    reset          = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (tb_rf[3] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_mid_rf: got %h expected deadbeef", tb_rf[3]);
    end
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd4;
    bus.req0_data  = 32'h0000_4444;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd8;
    bus.req1_data  = 32'h0000_8888;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_conflict: got %b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_scoreboard();
    test_same_edge();
    test_withdraw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
